// File: rtl/ctr_updown_mod.sv
// Parametrised synchronous up/down modulo-N counter with saturating parallel load,
// cascadable ripple carry/borrow (RCO) and a registered one-cycle wrap pulse.
module ctr_updown_mod #(
    parameter int unsigned      WIDTH   = 8,
    parameter longint unsigned  MODULUS = 256
) (
    input  logic             CP,
    input  logic             n_rst,
    input  logic             n_clr,
    input  logic             n_load,
    input  logic             ENP,
    input  logic             ENT,
    input  logic             UP,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             RCO,
    output logic             WRAP
);

    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 64'd1);
    localparam logic [WIDTH-1:0] ZERO_VAL = '0;
    localparam logic [WIDTH-1:0] ONE_VAL  = WIDTH'(1);

    // Reject parameter combinations the counter cannot represent.
    if (WIDTH < 1 || WIDTH > 32 || MODULUS < 64'd2 || MODULUS > (64'd1 << WIDTH)) begin : g_param_check
        $error("ctr_updown_mod: illegal WIDTH/MODULUS combination");
    end

    logic [WIDTH-1:0] q_nxt;
    logic             wrap_nxt;
    logic             at_top;
    logic             at_bottom;

    assign at_top    = (Q == MAX_VAL);
    assign at_bottom = (Q == ZERO_VAL);

    // Next-state selection: clear > load > count > hold.
    always_comb begin
        q_nxt    = Q;
        wrap_nxt = 1'b0;
        if (!n_clr) begin
            q_nxt = ZERO_VAL;
        end else if (!n_load) begin
            q_nxt = (D > MAX_VAL) ? MAX_VAL : D;
        end else if (ENP && ENT) begin
            if (UP) begin
                if (at_top) begin
                    q_nxt    = ZERO_VAL;
                    wrap_nxt = 1'b1;
                end else begin
                    q_nxt = Q + ONE_VAL;
                end
            end else begin
                if (at_bottom) begin
                    q_nxt    = MAX_VAL;
                    wrap_nxt = 1'b1;
                end else begin
                    q_nxt = Q - ONE_VAL;
                end
            end
        end
    end

    always_ff @(posedge CP or negedge n_rst) begin
        if (!n_rst) begin
            Q    <= ZERO_VAL;
            WRAP <= 1'b0;
        end else begin
            Q    <= q_nxt;
            WRAP <= wrap_nxt;
        end
    end

    // Terminal-count detect follows UP and ENT combinationally for cascading.
    assign RCO = ENT & (UP ? at_top : at_bottom);

endmodule

// File: doc/ctr_updown_mod.md
Name: ctr_updown_mod

Overview:
Parametrised synchronous up/down modulo-N counter; next generation of the team's 4-bit synchronous counter. Adds selectable width and modulus, count direction, an asynchronous power-on reset, and a registered wrap flag. Ripple-carry output stays cascadable through ENT/RCO so multi-stage counters (dividers, timebases, BCD digits) can be chained in the datapath.

Parameters:
WIDTH, 8, counter register width in bits (1..32)
MODULUS, 256, count range 0..MODULUS-1; legal range 2..2^WIDTH; out-of-range is an elaboration error

Ports:
CP  input  1  clock, rising edge active
n_rst  input  1  asynchronous active-low reset
n_clr  input  1  synchronous active-low clear
n_load  input  1  synchronous active-low parallel load
ENP  input  1  count enable, parallel (local)
ENT  input  1  count enable, trickle (cascade in); also gates RCO
UP  input  1  direction: 1 = up, 0 = down
D  input  WIDTH  parallel load data
Q  output  WIDTH  current count (register)
RCO  output  1  ripple carry/borrow out (combinational)
WRAP  output  1  registered one-cycle pulse after a wrap event

Behaviour:
- Reset: n_rst low -> Q=0, WRAP=0 immediately, no clock required; held while low. Release is synchronised by the user; the block takes no action on the release edge beyond resuming normal operation at the next CP rise.
- Priority per CP rising edge (n_rst high): n_clr > n_load > count > hold.
- n_clr=0: Q<=0, WRAP<=0. Ignores n_load, ENP, ENT, UP.
- n_clr=1, n_load=0: Q<=D if D<=MODULUS-1, else Q<=MODULUS-1 (saturating load). WRAP<=0.
- n_clr=1, n_load=1, ENP=1, ENT=1: count.
  - UP=1: Q==MODULUS-1 -> Q<=0, WRAP<=1; else Q<=Q+1, WRAP<=0.
  - UP=0: Q==0 -> Q<=MODULUS-1, WRAP<=1; else Q<=Q-1, WRAP<=0.
  - Arithmetic is modulo MODULUS, never modulo 2^WIDTH unless MODULUS=2^WIDTH (both then coincide).
- n_clr=1, n_load=1, ENP=0 or ENT=0: Q holds, WRAP<=0.
- RCO = ENT & (UP ? Q==MODULUS-1 : Q==0). Purely combinational from Q, UP and ENT. Independent of ENP, n_clr and n_load. 0 while n_rst low, since Q=0 and UP=1 gives no match. With UP=0 and Q=0 during reset, RCO=ENT.
- Cascade: stage k+1 ENT = stage k RCO; all stages share CP and ENP. Direction changes take effect on the same edge they are sampled. RCO reflects the new UP combinationally.
- UP toggled at the terminal value: the next count uses the sampled UP only. E.g. Q=MODULUS-1 with UP=0 -> Q<=MODULUS-2, no wrap.
- WRAP is exactly one cycle wide per wrap. Back-to-back wraps (MODULUS=2, continuous count) give WRAP high on consecutive cycles.
- No X propagation: every register has a defined value out of reset.
- Latency: load/clear/count visible on Q one cycle after the sampling edge. WRAP coincides with the Q value that follows the wrap.

Test Plan:
- WIDTH=4, MODULUS=10, async reset: from Q=7, pulse n_rst low mid-cycle -> Q=0, WRAP=0 before the next CP edge. Counting resumes from 0 after release.
- Decade up count, ENP=ENT=UP=1 from 0 -> Q sequences 0..9,0. RCO=1 only while Q=9. WRAP=1 for exactly the one cycle Q=0 after 9.
- Down count from load D=3, UP=0 -> Q 3,2,1,0,9,8. RCO=1 at Q=0. WRAP pulses with Q=9.
- Priority: n_clr=0 and n_load=0 with D=5 on the same edge -> Q=0. Next edge, n_clr=1, n_load=0, D=12 -> Q=9 (saturated load).
- Enables: at Q=9, ENP=0, ENT=1 -> Q holds 9, RCO=1. Then ENT=0 -> Q holds, RCO=0. No WRAP in either case.
- Two-stage cascade (MODULUS=10 each, stage1 ENT=stage0 RCO): 100 up clocks from 00 -> reads 99 then 00. Stage1 advances only on stage0 9->0 edges. Stage1 RCO high only at 99.
